// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller and the ALU-control decoder.
// Holds the state enum, opcode constants, datapath select encodings and the per-state control word.
package control_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore decode: the control word depends on the state alone.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALURESULT;
        c.adr_src    = 1'b0;
      end
      DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
        c.mem_write  = 1'b1;
      end
      EXECUTER: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_RD2;
        c.alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        // Plain add keeps immediate bit 30 from ever selecting subtract.
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      BEQ: begin
        c.alu_src_a  = SRCA_RD1;
        c.alu_src_b  = SRCB_RD2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational opcode-to-immediate-format decode; unsupported opcodes fall back to I-format.
module imm_src_decoder
  import control_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    imm_src = IMM_I;
    case (op)
      OP_LW, OP_ITYPE: imm_src = IMM_I;
      OP_SW:           imm_src = IMM_S;
      OP_BRANCH:       imm_src = IMM_B;
      OP_JAL:          imm_src = IMM_J;
      default:         imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// driving datapath enables and selects, and flagging unsupported instructions.
module main_control_fsm
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       IllegalOp
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       supported;
  logic [1:0] imm_src_raw;
  ctrl_t      ctrl;

  imm_src_decoder u_imm_src_decoder (
    .op      (op),
    .imm_src (imm_src_raw)
  );

  always_comb begin
    supported = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_JAL: supported = 1'b1;
      OP_ITYPE:                       supported = (funct3 == F3_ADDI);
      OP_BRANCH:                      supported = (funct3 == F3_BEQ);
      default:                        supported = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = FETCH;
    illegal_d = illegal_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (!supported) begin
          state_d   = FETCH;
          illegal_d = 1'b1;
        end else begin
          case (op)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYPE:     state_d = EXECUTER;
            OP_ITYPE:     state_d = EXECUTEI;
            OP_BRANCH:    state_d = BEQ;
            OP_JAL:       state_d = JAL;
            default:      state_d = FETCH;
          endcase
        end
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      MEMWB, MEMWRITE, ALUWB, BEQ: state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs are forced low while reset is high so an aborted instruction issues no strobes.
  always_comb begin
    ctrl = reset ? '0 : state_ctrl(state_q);
  end

  assign PCWrite   = ctrl.pc_update | (ctrl.branch & Zero);
  assign AdrSrc    = ctrl.adr_src;
  assign IRWrite   = ctrl.ir_write;
  assign MemWrite  = ctrl.mem_write;
  assign RegWrite  = ctrl.reg_write;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ImmSrc    = reset ? IMM_I : imm_src_raw;
  assign IllegalOp = illegal_q & ~reset;

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main controller for the RV32I-subset processor. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. It produces all datapath enables and mux selects, plus the 2-bit `ALUOp` consumed by the downstream ALU-control decoder. It sits between the instruction register (opcode/funct3 source) and the datapath/ALU-control stage, and it flags unsupported instructions.

## Interface
Parameters: none (all encodings are fixed constants in the shared package).

Ports:
- `clk`  in  1  Single clock. All state updates occur on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `op`  in  7  Opcode field, instr[6:0], from the instruction register.
- `funct3`  in  3  instr[14:12].
- `Zero`  in  1  ALU zero flag.
- `PCWrite`  out  1  Equals `PCUpdate | (Branch & Zero)`.
- `AdrSrc`  out  1  Memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  Instruction register / OldPC load.
- `MemWrite`  out  1  Data memory write strobe.
- `RegWrite`  out  1  Register file write strobe.
- `ResultSrc`  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = RD1.
- `ALUSrcB`  out  2  ALU operand B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `ALUOp`  out  2  ALU operation class: 00 = add, 01 = subtract, 10 = decode by funct.
- `ImmSrc`  out  2  Immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `IllegalOp`  out  1  Sticky unsupported-instruction flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Transitions:
  - FETCH→DECODE.
  - DECODE → MEMADR for lw (0000011) and sw (0100011).
  - DECODE → EXECUTER for R-type (0110011).
  - DECODE → EXECUTEI for addi (0010011 with funct3 = 000).
  - DECODE → BEQ for 1100011 with funct3 = 000.
  - DECODE → JAL for 1101111.
  - DECODE → FETCH for anything else, and `IllegalOp` sets.
  - MEMADR → MEMREAD for lw, → MEMWRITE for sw.
  - MEMREAD→MEMWB; EXECUTER and EXECUTEI → ALUWB; JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Outputs are a pure function of state. Any signal not listed for a state is 0.
  - FETCH: IRWrite=1, PCUpdate=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, AdrSrc=0.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. This computes the branch/jump target.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=00. addi never emits ALUOp=10, so immediate bit 30 cannot select subtract.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- `ImmSrc` is combinational from `op` in every state:
  - lw / addi → 00.
  - sw → 01.
  - beq → 10.
  - jal → 11.
  - other opcodes → 00.
- `IllegalOp` sets only in DECODE on an unsupported encoding, holds until `reset`, and does not halt sequencing.

## Timing
- Reset: while `reset` is high, the state register loads FETCH and every output, including `IllegalOp`, is driven 0. The first edge with `reset` low executes FETCH.
- Latency in cycles, FETCH through last state: lw 5, sw 4, R-type 4, addi 4, jal 4, beq 3, illegal 2.
- `PCWrite` in BEQ depends combinationally on the same-cycle `Zero`. All other outputs are registered-state decodes with no input dependence, apart from `ImmSrc`.
- `op` and `funct3` must be stable from DECODE to the end of the instruction (IR is loaded only in FETCH). The FSM samples them in DECODE and MEMADR only.
- Reset asserted mid-instruction aborts it at that edge: no further `MemWrite`/`RegWrite`, and the next state is FETCH.

## Structure
- Shared package `control_pkg`: state enum, opcode constants, and the `ALUOp`/`ResultSrc`/`ALUSrcA`/`ALUSrcB`/`ImmSrc` encodings, shared with the ALU-control decoder.
- Natural sub-module: `imm_src_decoder` (combinational op→`ImmSrc`).
- The FSM, output decode and `PCWrite` logic remain in `main_control_fsm`.

## Test plan
- Reset held for 2 cycles with op = 0000011 → all outputs 0. The first cycle after release shows IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (0000011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 with ResultSrc=01 only in cycle 5. Back to FETCH in cycle 6.
- sw (0100011) → MemWrite=1 with AdrSrc=1 only in cycle 4, and RegWrite is never asserted. ImmSrc=01 throughout.
- R-type (0110011) → ALUOp=10 in cycle 3 and RegWrite in cycle 4. addi (0010011, funct3 = 000) → ALUOp=00 with ALUSrcB=01 in cycle 3.
- beq (1100011): with Zero=1 in cycle 3 → PCWrite=1; with Zero=0 → PCWrite=0. Both cases return to FETCH in cycle 4.
- op = 1110011 → FETCH, DECODE, FETCH, with IllegalOp=1 from cycle 3 onward. A following valid addi still completes normally, IllegalOp stays 1, and reset clears it.
